rc6_core_param: RTL

Parametrised iterative RC6-w/r block cipher datapath. Encrypts or decrypts one 4W-bit block per transaction, selected per transaction. Uses valid/ready handshakes on both sides with output backpressure, and U rounds per clock. It sits between the RC6 key expander, which supplies the expanded table S[0..2R+3], and the image-stream framing logic. It supersedes the fixed 32/20, always-flowing core.

---
 rtl/rc6_core_param.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rc6_core_param.sv
// Iterative RC6-w/r block cipher core: one block per transaction, U rounds per clock,
// valid/ready handshakes with output backpressure; the key table is captured at accept.
module rc6_core_param #(
    parameter int W         = 32,
    parameter int R         = 20,
    parameter int U         = 1,
    parameter int BYTE_SWAP = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_dec,
    input  logic [W*(2*R+4)-1:0] i_keyex,
    input  logic [4*W-1:0]       i_din,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [4*W-1:0]       o_dout,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy
);

    localparam int LGW  = $clog2(W);
    localparam int NCYC = R / U;
    localparam int NK   = 2 * R + 4;
    localparam int KW   = $clog2(NK);
    localparam int CW   = $clog2(NCYC + 1);
    localparam logic [LGW-1:0] ROT_F = LGW'(LGW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic           dec;
    logic [W-1:0]   s_tab [NK];
    logic [W-1:0]   key_in [NK];
    logic [W-1:0]   a, b, c, d;
    logic [W-1:0]   la, lb, lc, ld;
    logic [W-1:0]   ra, rb, rc, rd;
    logic [W-1:0]   fa, fb, fc, fd;
    logic [W-1:0]   t, u, xa, xc;
    logic [KW-1:0]  ka, kc;
    logic [4*W-1:0] fin;
    logic           accept, last;
    int             base, rnd;

    function automatic logic [W-1:0] rol(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] y;
        y = {x, x} << n;
        return y[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] y;
        y = {x, x} >> n;
        return y[W-1:0];
    endfunction

    // {x[W-2:0],1} is 2x+1 modulo 2^W
    function automatic logic [W-1:0] f(input logic [W-1:0] x);
        logic [W-1:0] p;
        p = x * {x[W-2:0], 1'b1};
        return rol(p, ROT_F);
    endfunction

    function automatic logic [W-1:0] bswap(input logic [W-1:0] x);
        logic [W-1:0] y;
        for (int k = 0; k < W / 8; k++) y[8*k +: 8] = x[W-8-8*k +: 8];
        return (BYTE_SWAP != 0) ? y : x;
    endfunction

    always_comb begin
        for (int k = 0; k < NK; k++) key_in[k] = i_keyex[W*(NK-1-k) +: W];
    end

    always_comb begin
        la = bswap(i_din[4*W-1 -: W]);
        lb = bswap(i_din[3*W-1 -: W]);
        lc = bswap(i_din[2*W-1 -: W]);
        ld = bswap(i_din[W-1:0]);
        if (i_dec) begin
            lc = lc - key_in[2*R+3];
            la = la - key_in[2*R+2];
        end else begin
            lb = lb + key_in[0];
            ld = ld + key_in[1];
        end
    end

    // U unrolled rounds; the counter is clamped so the table index stays in range outside RUN
    always_comb begin
        ra = a; rb = b; rc = c; rd = d;
        t = '0; u = '0; xa = '0; xc = '0; ka = '0; kc = '0; rnd = 0;
        base = (int'(cnt) < NCYC) ? int'(cnt) * U : 0;
        for (int j = 0; j < U; j++) begin
            if (!dec) begin
                rnd = base + j + 1;
                ka  = KW'(2 * rnd);
                kc  = KW'(2 * rnd + 1);
                t   = f(rb);
                u   = f(rd);
                xa  = rol(ra ^ t, u[LGW-1:0]) + s_tab[ka];
                xc  = rol(rc ^ u, t[LGW-1:0]) + s_tab[kc];
                ra  = rb; rb = xc; rc = rd; rd = xa;
            end else begin
                rnd = R - base - j;
                ka  = KW'(2 * rnd);
                kc  = KW'(2 * rnd + 1);
                xa  = rd; rd = rc; rc = rb; rb = ra; ra = xa;
                u   = f(rd);
                t   = f(rb);
                rc  = ror(rc - s_tab[kc], t[LGW-1:0]) ^ u;
                ra  = ror(ra - s_tab[ka], u[LGW-1:0]) ^ t;
            end
        end
    end

    always_comb begin
        fa = ra; fb = rb; fc = rc; fd = rd;
        if (dec) begin
            fd = rd - s_tab[1];
            fb = rb - s_tab[0];
        end else begin
            fa = ra + s_tab[2*R+2];
            fc = rc + s_tab[2*R+3];
        end
        fin = {bswap(fa), bswap(fb), bswap(fc), bswap(fd)};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (i_ready) state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE) || ((state == DONE) && i_ready);
        o_busy  = (state != IDLE);
    end

    assign accept = i_valid && o_ready;
    assign last   = (state == RUN) && (cnt == CW'(NCYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt     <= '0;
            dec     <= 1'b0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
            d       <= '0;
            o_dout  <= '0;
            o_valid <= 1'b0;
            for (int k = 0; k < NK; k++) s_tab[k] <= '0;
        end else begin
            if (accept) begin
                dec <= i_dec;
                for (int k = 0; k < NK; k++) s_tab[k] <= key_in[k];
                a   <= la;
                b   <= lb;
                c   <= lc;
                d   <= ld;
                cnt <= '0;
            end else if (state == RUN) begin
                a   <= ra;
                b   <= rb;
                c   <= rc;
                d   <= rd;
                cnt <= cnt + CW'(1);
            end
            if (last) begin
                o_dout  <= fin;
                o_valid <= 1'b1;
            end else if ((state == DONE) && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
